slot_multi_task_fsm: RTL and testbench

- Parametrised slot-level control FSM that launches NUM_TASKS child tasks over the ap_ctrl handshake and reports slot completion upward.
- Adds three things the single-task generation lacks: a configurable child count, registered scalar capture at launch, and per-child "detached" mode where the parent waits only for launch, not for completion.
- Sits in each floorplan slot between the top-level ap_ctrl and the slot's child task instances.

---
 rtl/slot_multi_task_fsm.sv | 123 ++++++++++++
 tb/tb_slot_multi_task_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/slot_multi_task_fsm.sv
// rtl/slot_multi_task_fsm.sv - slot-level ap_ctrl FSM launching NUM_TASKS child tasks
module slot_multi_task_fsm #(
    parameter int                   NUM_TASKS     = 4,
    parameter int                   NUM_SCALARS   = 2,
    parameter int                   SCALAR_WIDTH  = 64,
    parameter logic [NUM_TASKS-1:0] DETACHED_MASK = {NUM_TASKS{1'b0}}
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst,
    input  logic                                ap_start,
    output logic                                ap_ready,
    output logic                                ap_done,
    output logic                                ap_idle,
    input  logic [NUM_SCALARS*SCALAR_WIDTH-1:0] scalar_in,
    output logic [NUM_SCALARS*SCALAR_WIDTH-1:0] scalar_out,
    output logic [NUM_TASKS-1:0]                task_ap_start,
    input  logic [NUM_TASKS-1:0]                task_ap_ready,
    input  logic [NUM_TASKS-1:0]                task_ap_done,
    input  logic [NUM_TASKS-1:0]                task_ap_idle,
    output logic [NUM_TASKS-1:0]                task_done_vec
);

    typedef enum logic [1:0] {
        TOP_IDLE   = 2'b00,
        TOP_RUN    = 2'b01,
        TOP_FINISH = 2'b10
    } top_state_t;

    typedef enum logic [1:0] {
        CHILD_IDLE  = 2'b00,
        CHILD_START = 2'b01,
        CHILD_WAIT  = 2'b11,
        CHILD_DONE  = 2'b10
    } child_state_t;

    top_state_t top_q;
    top_state_t top_d;
    logic       launch;
    logic       all_done;

    // Child idle status is observed by the parent only for debug; it never steers control.
    logic unused_task_idle;
    assign unused_task_idle = ^task_ap_idle;

    assign launch   = ap_start && (top_q == TOP_IDLE);
    assign all_done = &task_done_vec;
    assign ap_idle  = (top_q == TOP_IDLE);
    assign ap_done  = (top_q == TOP_FINISH);
    assign ap_ready = (top_q == TOP_FINISH);

    // Top state register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            top_q <= TOP_IDLE;
        end else begin
            top_q <= top_d;
        end
    end

    // Top next state: wait for every child, then a single FINISH cycle; 2'b11 falls back to IDLE.
    always_comb begin
        top_d = top_q;
        case (top_q)
            TOP_IDLE:   if (launch) top_d = TOP_RUN;
            TOP_RUN:    if (all_done) top_d = TOP_FINISH;
            TOP_FINISH: top_d = TOP_IDLE;
            default:    top_d = TOP_IDLE;
        endcase
    end

    // Scalars are captured once per launch and held for the children until the next launch.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            scalar_out <= '0;
        end else if (launch) begin
            scalar_out <= scalar_in;
        end
    end

    for (genvar i = 0; i < NUM_TASKS; i++) begin : g_child
        child_state_t child_q;
        child_state_t child_d;

        // Child state register.
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                child_q <= CHILD_IDLE;
            end else begin
                child_q <= child_d;
            end
        end

        // Child next state: detached children are complete as soon as they accept the start.
        always_comb begin
            child_d = child_q;
            case (child_q)
                CHILD_IDLE: begin
                    if (launch) child_d = CHILD_START;
                end
                CHILD_START: begin
                    if (task_ap_ready[i]) begin
                        if (DETACHED_MASK[i] || task_ap_done[i]) begin
                            child_d = CHILD_DONE;
                        end else begin
                            child_d = CHILD_WAIT;
                        end
                    end
                end
                CHILD_WAIT: begin
                    if (task_ap_done[i]) child_d = CHILD_DONE;
                end
                CHILD_DONE: begin
                    if (top_q == TOP_FINISH) child_d = CHILD_IDLE;
                end
                default: child_d = CHILD_IDLE;
            endcase
        end

        assign task_ap_start[i] = (child_q == CHILD_START);
        assign task_done_vec[i] = (child_q == CHILD_DONE);
    end

endmodule

// File: tb/tb_slot_multi_task_fsm.sv
// tb/tb_slot_multi_task_fsm.sv - directed self-checking bench for slot_multi_task_fsm
module tb_slot_multi_task_fsm;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int failures = 0;

    // single-task instance
    logic        st1, rdy1, dn1, done1, idle1;
    logic        ready1;
    logic [15:0] sin1, sout1;
    logic [0:0]  tstart1, tready1, tdone1, tidle1, tvec1;

    // four-task attached instance
    logic         st4, rdy4_o, dn4_o, idle4;
    logic [127:0] sin4, sout4;
    logic [3:0]   tstart4, tready4, tdone4, tidle4, tvec4;

    // four-task instance with child 1 detached
    logic         std, rdyd_o, dnd_o, idled;
    logic [15:0]  sind, soutd;
    logic [3:0]   tstartd, treadyd, tdoned, tidled, tvecd;

    int f [4] = '{5, 9, 2, 7};
    logic [3:0] exp_start, exp_vec, pulse;

    slot_multi_task_fsm #(.NUM_TASKS(1), .NUM_SCALARS(1), .SCALAR_WIDTH(16)) dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(st1), .ap_ready(ready1), .ap_done(done1),
        .ap_idle(idle1), .scalar_in(sin1), .scalar_out(sout1), .task_ap_start(tstart1),
        .task_ap_ready(tready1), .task_ap_done(tdone1), .task_ap_idle(tidle1), .task_done_vec(tvec1)
    );

    slot_multi_task_fsm dut4 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(st4), .ap_ready(rdy4_o), .ap_done(dn4_o),
        .ap_idle(idle4), .scalar_in(sin4), .scalar_out(sout4), .task_ap_start(tstart4),
        .task_ap_ready(tready4), .task_ap_done(tdone4), .task_ap_idle(tidle4), .task_done_vec(tvec4)
    );

    slot_multi_task_fsm #(.NUM_TASKS(4), .NUM_SCALARS(1), .SCALAR_WIDTH(16), .DETACHED_MASK(4'b0010)) dutd (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(std), .ap_ready(rdyd_o), .ap_done(dnd_o),
        .ap_idle(idled), .scalar_in(sind), .scalar_out(soutd), .task_ap_start(tstartd),
        .task_ap_ready(treadyd), .task_ap_done(tdoned), .task_ap_idle(tidled), .task_done_vec(tvecd)
    );

    assign rdy1 = ready1;
    assign dn1  = done1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        st1 = 0; sin1 = 16'h0; tready1 = 0; tdone1 = 0; tidle1 = 1;
        st4 = 0; sin4 = '0;    tready4 = 0; tdone4 = 0; tidle4 = 4'hF;
        std = 0; sind = 16'h0; treadyd = 0; tdoned = 0; tidled = 4'hF;

        // reset state
        #2;
        chk("rst_idle", idle4, 1'b1);
        chk("rst_done", dn4_o, 1'b0);
        chk("rst_ready", rdy4_o, 1'b0);
        chk("rst_start", tstart4, 4'h0);
        chk("rst_vec", tvec4, 4'h0);
        chk("rst_scalar", sout4, 128'h0);
        step();
        ap_rst = 0;
        step();

        // single task: ready+done in cycle 1
        st1 = 1; sin1 = 16'h5A5A;
        step();                                  // cycle 1
        st1 = 0;
        chk("t1_c1_start", tstart1, 1'b1);
        chk("t1_c1_idle", idle1, 1'b0);
        chk("t1_c1_scalar", sout1, 16'h5A5A);
        tready1 = 1; tdone1 = 1;
        step();                                  // cycle 2
        tready1 = 0; tdone1 = 0;
        chk("t1_c2_start", tstart1, 1'b0);
        chk("t1_c2_vec", tvec1, 1'b1);
        chk("t1_c2_done", dn1, 1'b0);
        step();                                  // cycle 3
        chk("t1_c3_done", dn1, 1'b1);
        chk("t1_c3_ready", rdy1, 1'b1);
        step();                                  // cycle 4
        chk("t1_c4_done", dn1, 1'b0);
        chk("t1_c4_idle", idle1, 1'b1);
        chk("t1_c4_vec", tvec1, 1'b0);

        // four children finishing at cycles 5, 9, 2, 7
        st4 = 1;
        step();
        st4 = 0;
        for (int c = 1; c <= 11; c++) begin
            for (int i = 0; i < 4; i++) begin
                exp_start[i] = (c < f[i]);
                exp_vec[i]   = (c >= f[i]) && (c <= 10);
                pulse[i]     = (c == f[i] - 1);
            end
            chk($sformatf("t4_c%0d_start", c), tstart4, exp_start);
            chk($sformatf("t4_c%0d_vec", c), tvec4, exp_vec);
            chk($sformatf("t4_c%0d_done", c), dn4_o, (c == 10));
            chk($sformatf("t4_c%0d_idle", c), idle4, (c == 11));
            tready4 = pulse; tdone4 = pulse;
            step();
        end
        tready4 = 0; tdone4 = 0;

        // scalar capture with ap_start held through the run
        st4 = 1; sin4 = {64'h2222, 64'h1111};
        step();                                  // cycle 1
        chk("sc_c1_scalar", sout4, {64'h2222, 64'h1111});
        sin4 = {64'hAAAA, 64'hAAAA};
        tready4 = 4'hF; tdone4 = 4'hF;
        step();                                  // cycle 2
        tready4 = 0; tdone4 = 0;
        chk("sc_c2_scalar", sout4, {64'h2222, 64'h1111});
        chk("sc_c2_norelaunch", tstart4, 4'h0);
        step();                                  // cycle 3
        st4 = 0;
        chk("sc_c3_done", dn4_o, 1'b1);
        chk("sc_c3_scalar", sout4, {64'h2222, 64'h1111});
        step();                                  // cycle 4
        chk("sc_c4_idle", idle4, 1'b1);
        chk("sc_c4_scalar", sout4, {64'h2222, 64'h1111});
        st4 = 1;
        step();
        st4 = 0;
        chk("sc_next_scalar", sout4, {64'hAAAA, 64'hAAAA});
        tready4 = 4'hF; tdone4 = 4'hF;
        step();
        tready4 = 0; tdone4 = 0;
        step();
        chk("sc_next_done", dn4_o, 1'b1);
        step();

        // detached child 1: ready at cycle 2, never done
        std = 1;
        step();                                  // cycle 1
        std = 0;
        chk("dt_c1_start", tstartd, 4'hF);
        step();                                  // cycle 2
        treadyd = 4'b0010;
        step();                                  // cycle 3
        treadyd = 0;
        chk("dt_c3_vec", tvecd, 4'b0010);
        chk("dt_c3_start", tstartd, 4'b1101);
        chk("dt_c3_done", dnd_o, 1'b0);
        step();                                  // cycle 4
        treadyd = 4'b1101; tdoned = 4'b1101;
        step();                                  // cycle 5
        treadyd = 0; tdoned = 0;
        chk("dt_c5_vec", tvecd, 4'hF);
        step();                                  // cycle 6
        chk("dt_c6_done", dnd_o, 1'b1);
        step();                                  // cycle 7
        chk("dt_c7_idle", idled, 1'b1);

        // ready withheld for 20 cycles, then two children move to WAIT
        st4 = 1; sin4 = {64'hDEAD, 64'hBEEF};
        step();
        st4 = 0;
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("hold_c%0d_start", c), tstart4, 4'hF);
            chk($sformatf("hold_c%0d_done", c), dn4_o, 1'b0);
            if (c == 20) tready4 = 4'b0011;
            step();
        end
        tready4 = 0;
        chk("hold_wait_start", tstart4, 4'b1100);
        chk("hold_wait_vec", tvec4, 4'b0000);

        // asynchronous reset mid-run
        #2;
        ap_rst = 1;
        #1;
        chk("arst_start", tstart4, 4'h0);
        chk("arst_scalar", sout4, 128'h0);
        chk("arst_idle", idle4, 1'b1);
        chk("arst_vec", tvec4, 4'h0);
        step();
        ap_rst = 0;
        step();
        st4 = 1; sin4 = {64'h3, 64'h4};
        step();                                  // cycle 1
        st4 = 0;
        chk("rl_c1_start", tstart4, 4'hF);
        chk("rl_c1_scalar", sout4, {64'h3, 64'h4});
        tready4 = 4'hF; tdone4 = 4'hF;
        step();                                  // cycle 2
        tready4 = 0; tdone4 = 0;
        chk("rl_c2_vec", tvec4, 4'hF);
        step();                                  // cycle 3
        chk("rl_c3_done", dn4_o, 1'b1);
        step();                                  // cycle 4
        chk("rl_c4_idle", idle4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
